// File: rtl/spi_write_ctrl.sv
//------------------------------------------------------------------------------
// Module   : spi_write_ctrl
// Summary  : SPI mode-0 write sequencer. It shifts one word out MSB first under
//            an active-low chip select, with bit timing set by an external divider tick.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_write_ctrl #(
   parameter int Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [Width-1:0] data_i,
   input  logic             tick_i,
   output logic             h_o,
   output logic             cs_o,
   output logic             sclk_o,
   output logic             mosi_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int c_CNT_W = $clog2(Width);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [Width-1:0]   r_shift;
   logic [Width-1:0]   w_shift_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               r_cs;
   logic               w_cs_nxt;
   logic               r_sclk;
   logic               w_sclk_nxt;
   logic               r_done;
   logic               w_done_nxt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_cs    <= 1'b1;
         r_sclk  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cs    <= w_cs_nxt;
         r_sclk  <= w_sclk_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // MOSI is the shift-register MSB; clearing the register at frame end returns MOSI to 0.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_cs_nxt    = r_cs;
      w_sclk_nxt  = r_sclk;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = S_SETUP;
               w_shift_nxt = data_i;
               w_cnt_nxt   = c_CNT_W'(Width - 1);
               w_cs_nxt    = 1'b0;
               w_sclk_nxt  = 1'b0;
            end
         end
         S_SETUP: begin
            if (tick_i) begin
               w_state_nxt = S_HIGH;
               w_sclk_nxt  = 1'b1;
            end
         end
         S_HIGH: begin
            if (tick_i) begin
               w_sclk_nxt = 1'b0;
               if (r_cnt == '0) begin
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_LOW;
                  w_shift_nxt = {r_shift[Width-2:0], 1'b0};
                  w_cnt_nxt   = r_cnt - c_CNT_W'(1);
               end
            end
         end
         S_LOW: begin
            if (tick_i) begin
               w_state_nxt = S_HIGH;
               w_sclk_nxt  = 1'b1;
            end
         end
         S_HOLD: begin
            if (tick_i) begin
               w_state_nxt = S_IDLE;
               w_shift_nxt = '0;
               w_cs_nxt    = 1'b1;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_shift_nxt = '0;
            w_cs_nxt    = 1'b1;
            w_sclk_nxt  = 1'b0;
         end
      endcase
   end

   assign h_o    = (r_state != S_IDLE);
   assign busy_o = (r_state != S_IDLE);
   assign cs_o   = r_cs;
   assign sclk_o = r_sclk;
   assign mosi_o = r_shift[Width-1];
   assign done_o = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_write_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_write_ctrl
// Summary  : Self-checking bench for spi_write_ctrl (Width 8 and Width 2) with a divider model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_write_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  start = '0;
   logic [1:0]  force_tick = '0;
   logic [1:0]  tick;
   logic [15:0] data [2];
   logic [1:0]  h, cs, sclk, mosi, busy, done;
   int          k = 3;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   bit          act [2];
   int          e0 [2];
   int          mk [2];
   logic [15:0] md [2];

   int          nrise [2];
   int          rise_cyc [2][64];
   int          ndone [2];
   int          done_t [2];
   int          cs_low [2];
   logic [15:0] bits [2];
   logic [1:0]  prev_sclk = '0;

   always #5 clk = ~clk;

   spi_write_ctrl #(.Width(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .data_i(data[0][7:0]),
      .tick_i(tick[0]), .h_o(h[0]), .cs_o(cs[0]), .sclk_o(sclk[0]),
      .mosi_o(mosi[0]), .busy_o(busy[0]), .done_o(done[0])
   );

   spi_write_ctrl #(.Width(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .data_i(data[1][1:0]),
      .tick_i(tick[1]), .h_o(h[1]), .cs_o(cs[1]), .sclk_o(sclk[1]),
      .mosi_o(mosi[1]), .busy_o(busy[1]), .done_o(done[1])
   );

   // Down-counter divider: sits at K while disabled, ticks every K+1 cycles when enabled.
   for (genvar g = 0; g < 2; g++) begin : g_div
      int cnt;
      always @(posedge clk or posedge rst) begin
         if (rst)                    cnt <= k;
         else if (!h[g] || cnt == 0) cnt <= k;
         else                        cnt <= cnt - 1;
      end
      assign tick[g] = force_tick[g] | (h[g] & (cnt == 0));
   end

   function automatic int w_of(input int i);
      return (i == 0) ? 8 : 2;
   endfunction

   // Cycle (counted from the accept edge) in which done_o is high.
   function automatic int done_at(input int w, input int kk);
      return (2 * w + 1) * (kk + 1) + 1;
   endfunction

   // Expected {h, cs, sclk, mosi, busy, done} in cycle t after the accept edge.
   function automatic logic [5:0] model_out(input int w, input int kk, input logic [15:0] d,
                                            input bit a, input int t);
      int n;
      int b;
      if (!a || t > done_at(w, kk)) return 6'b010000;
      if (t == done_at(w, kk))      return 6'b010001;
      n = (t - 1) / (kk + 1);
      b = (n / 2 > w - 1) ? w - 1 : n / 2;
      return {1'b1, 1'b0, n[0], d[w-1-b], 1'b1, 1'b0};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         act[0] = 1'b0;
         act[1] = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (start[i] && (!act[i] || cyc - e0[i] >= done_at(w_of(i), mk[i]))) begin
               act[i] = 1'b1;
               e0[i]  = cyc;
               mk[i]  = k;
               md[i]  = data[i];
            end
         end
         cyc = cyc + 1;
      end
   end

   always @(negedge clk) begin
      logic [5:0] exp_v;
      logic [5:0] got_v;
      for (int i = 0; i < 2; i++) begin
         exp_v = model_out(w_of(i), mk[i], md[i], act[i], cyc - e0[i]);
         got_v = {h[i], cs[i], sclk[i], mosi[i], busy[i], done[i]};
         tests++;
         if (got_v !== exp_v) begin
            fails++;
            $display("FAIL model_cmp inst%0d cycle %0d: {h,cs,sclk,mosi,busy,done} got %b want %b",
                     i, cyc, got_v, exp_v);
         end
         if (sclk[i] && !prev_sclk[i]) begin
            if (nrise[i] < 64) rise_cyc[i][nrise[i]] = cyc;
            nrise[i]++;
            bits[i] = {bits[i][14:0], mosi[i]};
         end
         prev_sclk[i] = sclk[i];
         if (done[i]) begin
            ndone[i]++;
            done_t[i] = cyc - e0[i];
         end
         if (!cs[i]) cs_low[i]++;
      end
   end

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic send(input int i, input logic [15:0] d, input logic with_tick);
      data[i]       = d;
      start[i]      = 1'b1;
      force_tick[i] = with_tick;
      @(negedge clk);
      start[i]      = 1'b0;
      force_tick[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      int n = 0;
      while (!done[i] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done[i]) begin
         tests++;
         fails++;
         $display("FAIL timeout inst%0d: no done_o within %0d cycles", i, budget);
      end
   endtask

   initial begin
      int n0, d0, c0, gmin, gmax, g, wr;
      data[0] = '0;
      data[1] = '0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      // Idle with one stray tick.
      repeat (4) @(negedge clk);
      force_tick = 2'b11;
      @(negedge clk);
      force_tick = 2'b00;
      repeat (5) @(negedge clk);
      #1;
      check("idle_out_w8", {h[0], cs[0], sclk[0], mosi[0], busy[0], done[0]}, 6'b010000);
      check("idle_out_w2", {h[1], cs[1], sclk[1], mosi[1], busy[1], done[1]}, 6'b010000);

      // 0xA5 at K=3, with a tick coinciding with the start.
      k = 3;
      @(negedge clk);
      n0 = nrise[0]; d0 = ndone[0]; c0 = cs_low[0];
      send(0, 16'h00A5, 1'b1);
      wait_done(0, 200);
      @(negedge clk); #1;
      gmin = 1000; gmax = 0;
      for (int j = n0 + 1; j < n0 + 8; j++) begin
         g = rise_cyc[0][j] - rise_cyc[0][j-1];
         if (g < gmin) gmin = g;
         if (g > gmax) gmax = g;
      end
      check("a5_rises", nrise[0] - n0, 8);
      check("a5_gap_min", gmin, 8);
      check("a5_gap_max", gmax, 8);
      check("a5_bits", int'(bits[0][7:0]), 8'hA5);
      check("a5_cs_low", cs_low[0] - c0, 68);
      check("a5_done_cnt", ndone[0] - d0, 1);
      check("a5_done_at", done_t[0], 69);

      // Back-to-back 0xFF then 0x00 at K=0.
      k = 0;
      @(negedge clk);
      n0 = nrise[0]; d0 = ndone[0]; c0 = cs_low[0];
      send(0, 16'h00FF, 1'b0);
      wait_done(0, 100);
      check("b2b_cs_gap", cs[0], 1);
      send(0, 16'h0000, 1'b0);
      check("b2b_cs_relow", cs[0], 0);
      wait_done(0, 100);
      @(negedge clk); #1;
      check("b2b_rises", nrise[0] - n0, 16);
      check("b2b_bits", int'(bits[0]), 16'hFF00);
      check("b2b_cs_low", cs_low[0] - c0, 34);
      check("b2b_done_cnt", ndone[0] - d0, 2);
      check("b2b_done_at", done_t[0], 18);

      // Starts while busy are dropped.
      k = 2;
      @(negedge clk);
      d0 = ndone[0];
      send(0, 16'h0081, 1'b0);
      for (int r = 0; r < 5; r++) begin
         repeat (6) @(negedge clk);
         send(0, 16'h003C, 1'b0);
      end
      wait_done(0, 100);
      repeat (10) @(negedge clk);
      #1;
      check("busy_bits", int'(bits[0][7:0]), 8'h81);
      check("busy_done_cnt", ndone[0] - d0, 1);
      check("busy_idle_after", busy[0], 0);

      // Asynchronous reset after the third rising SCLK.
      k = 1;
      @(negedge clk);
      n0 = nrise[0]; d0 = ndone[0];
      send(0, 16'h00C3, 1'b0);
      wr = 0;
      while (nrise[0] - n0 < 3 && wr < 100) begin
         @(negedge clk); #1;
         wr++;
      end
      check("rst_third_rise", nrise[0] - n0, 3);
      check("rst_pre_sclk", sclk[0], 1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_out", {h[0], cs[0], sclk[0], mosi[0], busy[0], done[0]}, 6'b010000);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_no_done", ndone[0] - d0, 0);
      send(0, 16'h005A, 1'b0);
      wait_done(0, 100);
      @(negedge clk); #1;
      check("rst_next_bits", int'(bits[0][7:0]), 8'h5A);
      check("rst_next_done_cnt", ndone[0] - d0, 1);
      check("rst_next_done_at", done_t[0], 35);

      // Minimum width: Width=2, K=1, data 2'b10.
      @(negedge clk);
      n0 = nrise[1]; d0 = ndone[1];
      send(1, 16'h0002, 1'b0);
      wait_done(1, 100);
      @(negedge clk); #1;
      check("w2_rises", nrise[1] - n0, 2);
      check("w2_bits", int'(bits[1][1:0]), 2);
      check("w2_done_at", done_t[1], 11);
      check("w2_done_cnt", ndone[1] - d0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_write_ctrl.md
# spi_write_ctrl

Sequencer for the SPI write path. It takes a parallel word on a start strobe and shifts it out MSB-first in SPI mode 0 (CPOL=0, CPHA=0). It frames the transfer with an active-low chip select. Bit timing comes from the tick-generating down-counter divider: this block drives the divider's count enable and consumes its tick output. It sits between the register/command logic and the SPI pins.

## Interface
- `Width`, default 16, number of data bits per transfer (≥2).
- `clk_i`  in  1  system clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  transfer request, sampled only in IDLE.
- `data_i`  in  Width  word to send, captured in the cycle `start_i` is accepted.
- `tick_i`  in  1  one-cycle pulse from the divider; ignored in IDLE.
- `h_o`  out  1  divider count enable; 1 in every state except IDLE.
- `cs_o`  out  1  chip select, active low.
- `sclk_o`  out  1  SPI clock.
- `mosi_o`  out  1  serial data, MSB first.
- `busy_o`  out  1  1 in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when a transfer completes.

## Operation
- All outputs are registered, or decoded from state with no input-to-output combinational path.
- Reset values: state=IDLE, `cs_o`=1, `sclk_o`=0, `mosi_o`=0, `h_o`=0, `busy_o`=0, `done_o`=0, shift register=0, bit counter=0.
- Internal storage:
  - Shift register, Width bits.
  - Bit counter, ceil(log2(Width)) bits; it holds the remaining bits minus 1.
- States and transitions; a tick means `tick_i`=1 in a non-IDLE state:
  - IDLE: outputs at their reset values, except `done_o`. On `start_i`=1: load the shift register from `data_i`, set counter=Width-1, drive `mosi_o`=`data_i`[Width-1], `cs_o`=0, `h_o`=1, and go to SETUP.
  - SETUP: `sclk_o`=0. On a tick: `sclk_o`=1 and go to HIGH.
  - HIGH: `sclk_o`=1. On a tick:
    - If counter=0: `sclk_o`=0 and go to HOLD.
    - Otherwise: `sclk_o`=0, shift left by 1, `mosi_o`=new MSB, decrement the counter, and go to LOW.
  - LOW: `sclk_o`=0. On a tick: `sclk_o`=1 and go to HIGH.
  - HOLD: `cs_o`=0, `sclk_o`=0. On a tick: `cs_o`=1, `h_o`=0, `mosi_o`=0, `done_o`=1 for one cycle, and go to IDLE.
- `mosi_o` changes only on falling `sclk_o` edges or at SETUP entry, so it is stable across every rising edge.
- `start_i` is ignored while `busy_o`=1; there is no queueing. `data_i` is don't-care outside the accept cycle.
- A `start_i` arriving in the IDLE cycle where `done_o`=1 is accepted. The result is back-to-back transfers with `cs_o` high for exactly 1 cycle.
- A `tick_i` in the same cycle as `start_i` in IDLE is ignored; the state still goes to SETUP.
- Reset asserted mid-transfer forces all reset values immediately, without waiting for a clock edge. No `done_o` is produced. The partial frame is abandoned.

## Timing
- Let K be the divider reload value. Ticks arrive every K+1 cycles while `h_o`=1.
  - After idle the divider sits at K, so the first tick is sampled K+1 cycles after SETUP entry.
- Each transfer takes exactly 2·Width+1 ticks, counted from SETUP entry to the IDLE transition that raises `done_o`.
  - This is (2·Width+1)·(K+1) cycles.
  - Add 1 cycle from the `start_i` sample edge to SETUP entry.
- `sclk_o` period is 2·(K+1) cycles at 50% duty.
- Setup from `cs_o` falling to the first rising `sclk_o` edge: K+1 cycles, plus the 1-cycle accept edge.
- Hold from the last falling `sclk_o` edge to `cs_o` rising: K+1 cycles.
- `done_o` and `cs_o` rising occur on the same edge; `busy_o` falls on that same edge.

## Test plan
- Reset, then idle for 10 cycles. Required: `cs_o`=1, `sclk_o`=0, `mosi_o`=0, `h_o`=0, `busy_o`=0, `done_o`=0 throughout, even though the divider tick pulses once after reset.
- Width=8, K=3, `data_i`=0xA5, one `start_i` pulse. Required:
  - 8 rising `sclk_o` edges, 8 cycles apart.
  - Bits sampled on the rising edges read 1,0,1,0,0,1,0,1.
  - `cs_o` is low for 68 cycles after the accept edge.
  - `done_o` pulses once, 69 cycles after the accept edge.
- Width=8, K=0, `data_i`=0xFF, then 0x00 started in the `done_o` cycle. Required:
  - Two frames separated by exactly 1 cycle of `cs_o` high.
  - `mosi_o` reads all 1s, then all 0s.
  - Each frame spans 17 cycles.
- Pulse `start_i` repeatedly with `data_i`=0x3C during a 0x81 transfer. Required: only 0x81 is shifted, and exactly one `done_o` pulse occurs.
- Assert `rst_i` asynchronously mid-transfer, after the 3rd rising `sclk_o`. Required:
  - Outputs return to reset values with no clock edge.
  - No `done_o` pulse occurs.
  - A following start of 0x5A completes correctly.
- Width=2, K=1, `data_i`=2'b10. Required: 2 `sclk_o` rising edges with `mosi_o` 1 then 0, and `done_o` pulses 11 cycles after the accept edge.
